// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage of the RISC-V core.
//
// Holds the instruction leaving the MEM stage in a pipeline register.
// It extracts and extends load data from the data memory read word. It
// selects the value written to the register file and drops writes to x0.
// It mirrors the write port onto a forwarding tap for the hazard unit and
// counts retired instructions.
//
// Parameters
//   XLEN       datapath width (only 32 is supported)
//   CNT_WIDTH  width of the retired-instruction counter
//
// Ports
//   clk            core clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   stall          hold the WB register contents (has priority over flush)
//   flush          load a bubble instead of the incoming instruction
//   in_valid       MEM stage holds a real instruction
//   in_reg_write   instruction writes rd
//   in_rd          destination register
//   in_wb_sel      00 ALU, 01 MEM, 10 PC+4, 11 ALU (reserved)
//   in_funct3      load size / signedness
//   in_alu_result  ALU result, also the load byte address
//   in_pc          instruction PC
//   mem_rdata      data memory read word, valid while the load sits in WB
//   rf_we/wa/wd    register file write port
//   fwd_valid/addr/data  forwarding tap, identical to the write port
//   instret        retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_reg_write,
    input  logic [4:0]           in_rd,
    input  logic [1:0]           in_wb_sel,
    input  logic [2:0]           in_funct3,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 rf_we,
    output logic [4:0]           rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_addr,
    output logic [XLEN-1:0]      fwd_data,
    output logic [CNT_WIDTH-1:0] instret
);

    // Writeback source select encoding.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_ALU2 = 2'b11
    } wb_sel_e;

    // Load funct3 encodings; anything else behaves as a full word.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // -------------------------------------------------------------------------
    // Pipeline register
    // -------------------------------------------------------------------------
    logic                 v_q,     v_d;
    logic                 rw_q,    rw_d;
    logic [4:0]           rd_q,    rd_d;
    wb_sel_e              sel_q,   sel_d;
    logic [2:0]           f3_q,    f3_d;
    logic [XLEN-1:0]      alu_q,   alu_d;
    logic [XLEN-1:0]      pc_q,    pc_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    logic retire;

    // An instruction leaves WB on any edge where the slot is valid and not
    // held. Stores, branches and x0 writes count as well.
    assign retire = v_q & ~stall;

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // block leaves one unassigned and no latch is inferred.
        v_d       = v_q;
        rw_d      = rw_q;
        rd_d      = rd_q;
        sel_d     = sel_q;
        f3_d      = f3_q;
        alu_d     = alu_q;
        pc_d      = pc_q;
        instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, retire};

        if (!stall) begin
            if (flush) begin
                // Bubble: only the control bits matter. The datapath
                // fields keep their old values.
                v_d  = 1'b0;
                rw_d = 1'b0;
            end else begin
                v_d   = in_valid;
                rw_d  = in_reg_write;
                rd_d  = in_rd;
                sel_d = wb_sel_e'(in_wb_sel);
                f3_d  = in_funct3;
                alu_d = in_alu_result;
                pc_d  = in_pc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before the edge and never from a
    // sibling flop updated in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the datapath fields are reset along with the control
            // bits. This keeps rf_wa/rf_wd free of X right after reset,
            // even while mem_rdata is still undriven.
            v_q       <= 1'b0;
            rw_q      <= 1'b0;
            rd_q      <= '0;
            sel_q     <= WB_ALU;
            f3_q      <= '0;
            alu_q     <= '0;
            pc_q      <= '0;
            instret_q <= '0;
        end else begin
            v_q       <= v_d;
            rw_q      <= rw_d;
            rd_q      <= rd_d;
            sel_q     <= sel_d;
            f3_q      <= f3_d;
            alu_q     <= alu_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    // -------------------------------------------------------------------------
    // Load extraction
    // -------------------------------------------------------------------------
    logic [1:0]      byte_off;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;

    assign byte_off = alu_q[1:0];

    always_comb begin
        load_byte = mem_rdata[7:0];
        unique case (byte_off)
            2'd0: load_byte = mem_rdata[7:0];
            2'd1: load_byte = mem_rdata[15:8];
            2'd2: load_byte = mem_rdata[23:16];
            2'd3: load_byte = mem_rdata[31:24];
            default: load_byte = mem_rdata[7:0];
        endcase
    end

    // Halfword selection uses only off[1]. A misaligned halfword silently
    // reads the aligned halfword that contains it, and no trap is raised.
    assign load_half = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (f3_q)
            F3_LB:   load_data = {{(XLEN-8){load_byte[7]}},   load_byte};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}},           load_byte};
            F3_LH:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}},          load_half};
            // LW plus the reserved encodings 011, 110, 111.
            default: load_data = mem_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Writeback mux and write port
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] link_addr;

    // Return address for JAL/JALR. It wraps modulo 2^XLEN.
    assign link_addr = pc_q + XLEN'(4);

    // mem_rdata reaches the output only when the MEM source is selected.
    // An undriven memory bus therefore cannot put X on rf_wd for other
    // sources.
    always_comb begin
        unique case (sel_q)
            WB_MEM:  wb_data = load_data;
            WB_PC4:  wb_data = link_addr;
            WB_ALU,
            WB_ALU2: wb_data = alu_q;
            default: wb_data = alu_q;
        endcase
    end

    // The write enable depends only on registered state. It stays high
    // through a stall, and rewriting the same value is harmless.
    assign rf_we = v_q & rw_q & (rd_q != 5'd0);
    assign rf_wa = rd_q;
    assign rf_wd = wb_data;

    // The forwarding tap is the write port itself. It adds no latency.
    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_wa;
    assign fwd_data  = rf_wd;

    assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// Directed vectors come from a table, followed by hand-written stall, flush
// and reset sequences and a randomized run. All checks compare against a
// reference model that tracks the instruction occupying WB.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        in_valid, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_pc, mem_rdata;
    logic        rf_we, fwd_valid;
    logic [4:0]  rf_wa, fwd_addr;
    logic [31:0] rf_wd, fwd_data, instret;

    wb_stage #(.XLEN(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_pc(in_pc), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .instret(instret)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the instruction now in WB, plus the retire count.
    // ------------------------------------------------------------------
    typedef struct {
        bit          v, rw;
        bit [4:0]    rd;
        bit [1:0]    sel;
        bit [2:0]    f3;
        bit [31:0]   alu, pc;
    } slot_t;

    slot_t       m_slot;
    bit   [31:0] m_cnt;

    // Load value from the architectural rule: shift the addressed unit
    // down, then sign- or zero-extend it according to funct3.
    function automatic bit [31:0] ref_load(bit [2:0] f3, bit [31:0] addr,
                                           bit [31:0] word);
        bit [31:0] sh;
        case (f3)
            3'b000, 3'b100: begin
                sh = (word >> (8 * addr[1:0])) & 32'hFF;
                if (f3 == 3'b000 && sh >= 32'h80) sh = sh - 32'h100;
            end
            3'b001, 3'b101: begin
                sh = (word >> (16 * addr[1])) & 32'hFFFF;
                if (f3 == 3'b001 && sh >= 32'h8000) sh = sh - 32'h1_0000;
            end
            default: sh = word;
        endcase
        return sh;
    endfunction

    function automatic bit exp_we();
        return m_slot.v && m_slot.rw && (m_slot.rd != 0);
    endfunction

    function automatic bit [31:0] exp_wd(bit [31:0] word);
        if (m_slot.sel == 2'b01) return ref_load(m_slot.f3, m_slot.alu, word);
        if (m_slot.sel == 2'b10) return m_slot.pc + 32'd4;
        return m_slot.alu;
    endfunction

    // Advance the model from the inputs presented before the edge, then
    // take the edge and let the outputs settle.
    task automatic tick();
        if (!rst_n) begin
            m_slot = '{default: 0};
            m_cnt  = 0;
        end else if (!stall) begin
            if (m_slot.v) m_cnt++;
            if (flush) begin
                m_slot.v  = 0;
                m_slot.rw = 0;
            end else begin
                m_slot = '{v: in_valid, rw: in_reg_write, rd: in_rd,
                           sel: in_wb_sel, f3: in_funct3,
                           alu: in_alu_result, pc: in_pc};
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the model. Address and data are checked
    // only when a write is expected, since a bubble's fields are don't-care.
    task automatic check_model(input string tag);
        check({tag, " rf_we"},     32'(rf_we),     32'(exp_we()));
        check({tag, " fwd_valid"}, 32'(fwd_valid), 32'(exp_we()));
        check({tag, " instret"},   instret,        m_cnt);
        if (exp_we()) begin
            check({tag, " rf_wa"},    32'(rf_wa),    32'(m_slot.rd));
            check({tag, " fwd_addr"}, 32'(fwd_addr), 32'(m_slot.rd));
            check({tag, " rf_wd"},    rf_wd,         exp_wd(mem_rdata));
            check({tag, " fwd_data"}, fwd_data,      exp_wd(mem_rdata));
        end
    endtask

    task automatic drive(input bit v, input bit rw, input bit [4:0] rd,
                         input bit [1:0] sel, input bit [2:0] f3,
                         input bit [31:0] alu, input bit [31:0] pc);
        in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
        in_funct3 = f3; in_alu_result = alu; in_pc = pc;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        bit          rw;
        bit [4:0]    rd;
        bit [1:0]    sel;
        bit [2:0]    f3;
        bit [31:0]   alu, pc, mem;
        bit          exp_we;
        bit [31:0]   exp_wd;
    } vec_t;

    localparam int NVEC = 16;
    localparam bit [31:0] W = 32'h8070_F0A5;
    vec_t tbl [NVEC];

    initial begin
        tbl[0]  = '{"alu_rd5",   1, 5, 2'b00, 3'b000, 32'h1234_5678, 32'h0,   32'h0, 1, 32'h1234_5678};
        tbl[1]  = '{"x0_write",  1, 0, 2'b00, 3'b000, 32'hFFFF_FFFF, 32'h0,   32'h0, 0, 32'hFFFF_FFFF};
        tbl[2]  = '{"lb_off0",   1, 2, 2'b01, 3'b000, 32'h0000_1000, 32'h0,   W,     1, 32'hFFFF_FFA5};
        tbl[3]  = '{"lbu_off1",  1, 3, 2'b01, 3'b100, 32'h0000_1001, 32'h0,   W,     1, 32'h0000_00F0};
        tbl[4]  = '{"lb_off2",   1, 4, 2'b01, 3'b000, 32'h0000_1002, 32'h0,   W,     1, 32'h0000_0070};
        tbl[5]  = '{"lh_off2",   1, 6, 2'b01, 3'b001, 32'h0000_1002, 32'h0,   W,     1, 32'hFFFF_8070};
        tbl[6]  = '{"lhu_off0",  1, 7, 2'b01, 3'b101, 32'h0000_1000, 32'h0,   W,     1, 32'h0000_F0A5};
        tbl[7]  = '{"lw",        1, 8, 2'b01, 3'b010, 32'h0000_1000, 32'h0,   W,     1, 32'h8070_F0A5};
        tbl[8]  = '{"f3_111",    1, 9, 2'b01, 3'b111, 32'h0000_1003, 32'h0,   W,     1, 32'h8070_F0A5};
        tbl[9]  = '{"lb_off3",   1, 10, 2'b01, 3'b000, 32'h0000_1003, 32'h0,  W,     1, 32'hFFFF_FF80};
        tbl[10] = '{"lh_off3",   1, 11, 2'b01, 3'b001, 32'h0000_1003, 32'h0,  W,     1, 32'hFFFF_8070};
        tbl[11] = '{"lhu_off1",  1, 12, 2'b01, 3'b101, 32'h0000_1001, 32'h0,  W,     1, 32'h0000_F0A5};
        tbl[12] = '{"jal_wrap",  1, 1, 2'b10, 3'b000, 32'h0,         32'hFFFF_FFFC, 32'h0, 1, 32'h0000_0000};
        tbl[13] = '{"jal_100",   1, 1, 2'b10, 3'b000, 32'h0,         32'h0000_0100, 32'h0, 1, 32'h0000_0104};
        tbl[14] = '{"sel_11",    1, 13, 2'b11, 3'b000, 32'hDEAD_BEEF, 32'h0,  32'h0, 1, 32'hDEAD_BEEF};
        tbl[15] = '{"store",     0, 14, 2'b00, 3'b000, 32'hCAFE_0000, 32'h0,  32'h0, 0, 32'hCAFE_0000};
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        bit [31:0] c0;
        m_slot = '{default: 0};
        m_cnt  = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        mem_rdata = 'x;

        // Reset held for two edges; outputs must be defined and idle.
        tick(); tick();
        check("reset rf_we",     32'(rf_we),     32'd0);
        check("reset fwd_valid", 32'(fwd_valid), 32'd0);
        check("reset instret",   instret,        32'd0);
        check("reset rf_wd",     32'($isunknown(rf_wd)), 32'd0);
        rst_n = 1'b1;

        // Directed table, back to back. mem_rdata is presented in WB cycle.
        for (int i = 0; i < NVEC; i++) begin
            drive(1, tbl[i].rw, tbl[i].rd, tbl[i].sel, tbl[i].f3,
                  tbl[i].alu, tbl[i].pc);
            mem_rdata = 'x;
            tick();
            if (tbl[i].sel == 2'b01) mem_rdata = tbl[i].mem;
            #1;
            check({tbl[i].name, " rf_we"},     32'(rf_we),     32'(tbl[i].exp_we));
            check({tbl[i].name, " fwd_valid"}, 32'(fwd_valid), 32'(tbl[i].exp_we));
            check({tbl[i].name, " rf_wa"},     32'(rf_wa),     32'(tbl[i].rd));
            check({tbl[i].name, " rf_wd"},     rf_wd,          tbl[i].exp_wd);
            check({tbl[i].name, " fwd_data"},  fwd_data,       tbl[i].exp_wd);
            check({tbl[i].name, " instret"},   instret,        32'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        mem_rdata = 'x;
        tick();
        check("table retire count", instret, 32'(NVEC));

        // Stall for three cycles while inputs change.
        drive(1, 1, 7, 2'b00, 3'b000, 32'h0000_0077, 32'h0);
        tick();
        c0 = m_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(20 + i), 2'b00, 3'b000, $urandom, 32'h0);
            tick();
            check("stall rf_wa",   32'(rf_wa), 32'd7);
            check("stall rf_we",   32'(rf_we), 32'd1);
            check("stall rf_wd",   rf_wd,      32'h0000_0077);
            check("stall instret", instret,    c0);
        end
        stall = 1'b0;
        drive(1, 1, 8, 2'b00, 3'b000, 32'h0000_0088, 32'h0);
        tick();
        check("unstall instret", instret, c0 + 32'd1);
        check("unstall rf_wa",   32'(rf_wa), 32'd8);

        // Stall and flush together: stall wins, contents held.
        stall = 1'b1; flush = 1'b1;
        tick();
        check("stall+flush rf_wa", 32'(rf_wa), 32'd8);
        check("stall+flush rf_we", 32'(rf_we), 32'd1);
        check("stall+flush instret", instret,  c0 + 32'd1);

        // Flush alone: rd=8 retires, a bubble enters.
        stall = 1'b0;
        tick();
        check("flush rf_we",   32'(rf_we), 32'd0);
        check("flush instret", instret,    c0 + 32'd2);
        tick();
        check("bubble instret", instret,   c0 + 32'd2);
        flush = 1'b0;
        check_model("post-flush");

        // Reset while a write to rd=9 is stalled.
        drive(1, 1, 9, 2'b00, 3'b000, 32'h0000_0099, 32'h0);
        tick();
        stall = 1'b1;
        tick();
        check("pre-reset rf_we", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midreset rf_we",   32'(rf_we), 32'd0);
        check("midreset instret", instret,    32'd0);
        rst_n = 1'b1; stall = 1'b0;
        drive(0, 1, 9, 2'b00, 3'b000, 32'h0000_0099, 32'h0);
        tick();
        check("post-reset rf_we",   32'(rf_we), 32'd0);
        check("post-reset instret", instret,    32'd0);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 15);
            drive($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 75,
                  5'($urandom_range(0, 31)), 2'($urandom), 3'($urandom),
                  $urandom, $urandom);
            mem_rdata = 'x;
            tick();
            mem_rdata = $urandom;
            #1;
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
